// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer
//   Command stage in front of the I2C master FSM and the address-translator FSM.
//   Host requests (rw, slave select, data byte) are queued in a small FIFO and
//   issued one at a time. Each issue is a one-cycle txn_start pulse. The request
//   fields stay stable until the transaction completes or times out. A fixed
//   idle gap is then inserted before the next start.
//
//   Optional feature macro: I2C_SEQ_RETRY_EN
//     defined   : the first timeout of a command re-issues the same fields after
//                 the gap; the second timeout flags err_timeout and drops it.
//     undefined : the first timeout flags err_timeout and drops the command.
//
// Ports
//   clk, reset          I2C-domain clock; asynchronous active-high reset
//   cmd_valid/ready     host push handshake (push = cmd_valid & cmd_ready)
//   cmd_rw/slave_sel/data
//                       command fields captured on push
//   txn_start           one-cycle pulse when a transaction begins
//   txn_rw/slave_sel/data
//                       fields for the current transaction, changed only in LOAD
//   txn_done            completion from master/translator (level or pulse)
//   busy                high whenever the sequencer is not idle
//   fifo_level          number of queued commands
//   err_clr/err_timeout sticky timeout flag and its clear
//   done_count          wrapping count of successful completions
module i2c_txn_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 8,
  parameter int CNT_W          = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic                        cmd_slave_sel,
  input  logic [7:0]                  cmd_data,
  output logic                        txn_start,
  output logic                        txn_rw,
  output logic                        txn_slave_sel,
  output logic [7:0]                  txn_data,
  input  logic                        txn_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        err_clr,
  output logic                        err_timeout,
  output logic [CNT_W-1:0]            done_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             state_r;
  logic [9:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic               push_s;
  logic               pop_s;
  logic [9:0]         head_s;
  logic               done_q_r;
  logic               done_q_d_r;
  logic               done_edge_s;
  logic               timeout_s;
  logic               err_set_s;
  logic [TO_W-1:0]    to_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
`ifdef I2C_SEQ_RETRY_EN
  logic               retry_used_r;
  logic               retry_pend_r;
`endif

  // cmd_ready is registered !full, so a full FIFO refuses a push even when LOAD pops
  assign push_s = cmd_valid & cmd_ready;
  // LOAD is only entered with a non-empty FIFO and nothing else removes entries
  assign pop_s  = (state_r == ST_LOAD);
  assign head_s = mem_r[rd_ptr_r];

  // Occupancy after this cycle's push/pop
  always_comb begin
    level_nxt_s = fifo_level;
    if (push_s && !pop_s) begin
      level_nxt_s = fifo_level + LVL_W'(1'b1);
    end else if (!push_s && pop_s) begin
      level_nxt_s = fifo_level - LVL_W'(1'b1);
    end else begin
      level_nxt_s = fifo_level;
    end
  end

  // FIFO pointers, level and ready flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_level <= {LVL_W{1'b0}};
      cmd_ready  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      fifo_level <= level_nxt_s;
      cmd_ready  <= (level_nxt_s != LVL_FULL);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {cmd_rw, cmd_slave_sel, cmd_data};
  end

  // Register txn_done once and keep a delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q_r   <= 1'b0;
      done_q_d_r <= 1'b0;
    end else begin
      done_q_r   <= txn_done;
      done_q_d_r <= done_q_r;
    end
  end

  // A done level left high from an earlier transaction produces no new edge
  assign done_edge_s = done_q_r & ~done_q_d_r;
  // Completion on the last counted cycle takes priority over the timeout
  assign timeout_s   = (state_r == ST_WAIT) & ~done_edge_s & (to_cnt_r == TO_LAST);
`ifdef I2C_SEQ_RETRY_EN
  assign err_set_s   = timeout_s & retry_used_r;
`else
  assign err_set_s   = timeout_s;
`endif

  // Sticky timeout flag; a coincident set beats the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (err_set_s) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end

  // Transaction sequencer: IDLE -> LOAD -> START -> WAIT -> GAP -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      txn_start     <= 1'b0;
      txn_rw        <= 1'b0;
      txn_slave_sel <= 1'b0;
      txn_data      <= 8'h00;
      busy          <= 1'b0;
      done_count    <= {CNT_W{1'b0}};
      to_cnt_r      <= {TO_W{1'b0}};
      gap_cnt_r     <= {GAP_W{1'b0}};
`ifdef I2C_SEQ_RETRY_EN
      retry_used_r  <= 1'b0;
      retry_pend_r  <= 1'b0;
`endif
    end else begin
      txn_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fifo_level != {LVL_W{1'b0}}) begin
            state_r <= ST_LOAD;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        ST_LOAD: begin
          {txn_rw, txn_slave_sel, txn_data} <= head_s;
          to_cnt_r  <= {TO_W{1'b0}};
`ifdef I2C_SEQ_RETRY_EN
          retry_used_r <= 1'b0;
`endif
          txn_start <= 1'b1;
          state_r   <= ST_START;
        end
        ST_START: begin
          // also reached on a retry, so the timeout window restarts here
          to_cnt_r <= {TO_W{1'b0}};
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          gap_cnt_r <= {GAP_W{1'b0}};
          if (done_edge_s) begin
            done_count <= done_count + CNT_W'(1'b1);
            state_r    <= ST_GAP;
          end else if (to_cnt_r == TO_LAST) begin
`ifdef I2C_SEQ_RETRY_EN
            if (!retry_used_r) begin
              retry_used_r <= 1'b1;
              retry_pend_r <= 1'b1;
            end
`endif
            state_r <= ST_GAP;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_pend_r) begin
              // re-issue the held fields without popping
              retry_pend_r <= 1'b0;
              txn_start    <= 1'b1;
              state_r      <= ST_START;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
`else
            state_r <= ST_IDLE;
            busy    <= 1'b0;
`endif
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a queue of expected transactions.
module tb_i2c_txn_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 64;
  localparam int GAP   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic       cmd_slave_sel;
  logic [7:0] cmd_data;
  logic       txn_start;
  logic       txn_rw;
  logic       txn_slave_sel;
  logic [7:0] txn_data;
  logic       txn_done;
  logic       busy;
  logic [2:0] fifo_level;
  logic       err_clr;
  logic       err_timeout;
  logic [7:0] done_count;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         exp_cnt = 0;
  int         start_cnt = 0;
  int         s0;
  int         exp_starts;
  logic [9:0] exp_q[$];

  i2c_txn_sequencer #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_slave_sel(cmd_slave_sel), .cmd_data(cmd_data),
    .txn_start(txn_start), .txn_rw(txn_rw), .txn_slave_sel(txn_slave_sel),
    .txn_data(txn_data), .txn_done(txn_done), .busy(busy),
    .fifo_level(fifo_level), .err_clr(err_clr), .err_timeout(err_timeout),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  // count every start pulse seen on the bus
  always @(posedge clk) begin
    if (txn_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no end of test, required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present one command for one edge; called #1 after a rising edge
  task automatic push(input logic rw, input logic sel, input logic [7:0] d, input logic exp_rdy);
    cmd_rw = rw; cmd_slave_sel = sel; cmd_data = d; cmd_valid = 1'b1;
    check("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_rdy});
    if (exp_rdy) exp_q.push_back({rw, sel, d});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // wait for a start pulse (sampled on falling edges) and score its fields
  task automatic wait_start(input string tag);
    logic [9:0] e;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txn_start !== 1'b1 && n < 300);
    check({tag, "_start"}, {31'd0, txn_start}, 32'd1);
    check({tag, "_qnonempty"}, {31'd0, (exp_q.size() != 0)}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_fields"}, {22'd0, txn_rw, txn_slave_sel, txn_data}, {22'd0, e});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 400);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 txn_done = 1'b1;
    @(posedge clk); #1 txn_done = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_slave_sel = 1'b0;
    cmd_data = 8'h00; txn_done = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_start", {31'd0, txn_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    check("rst_count", {24'd0, done_count}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single write, start three clocks after the push is presented
    push(1'b0, 1'b0, 8'hA5, 1'b1);
    check("t1_level", {29'd0, fifo_level}, 32'd1);
    @(posedge clk); #1;
    check("t1_start_early", {31'd0, txn_start}, 32'd0);
    check("t1_busy_load", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("t1_start", {31'd0, txn_start}, 32'd1);
    check("t1_fields", {22'd0, txn_rw, txn_slave_sel, txn_data}, {22'd0, exp_q.pop_front()});
    @(posedge clk); #1;
    check("t1_start_once", {31'd0, txn_start}, 32'd0);
    check("t1_data_held", {24'd0, txn_data}, 32'h0000_00A5);
    check("t1_level_pop", {29'd0, fifo_level}, 32'd0);
    txn_done = 1'b1;
    @(posedge clk); #1 txn_done = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 1;
    check("t1_count", {24'd0, done_count}, exp_cnt);
    repeat (GAP - 1) @(posedge clk);
    #1;
    check("t1_busy_gap", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("t1_busy_low", {31'd0, busy}, 32'd0);

    // 2: fill the FIFO while a transaction is outstanding
    push(1'b1, 1'b1, 8'h3C, 1'b1);
    wait_start("t2_x");
    @(posedge clk); #1;
    push(1'b0, 1'b1, 8'h11, 1'b1);
    push(1'b1, 1'b0, 8'h22, 1'b1);
    push(1'b0, 1'b0, 8'h33, 1'b1);
    push(1'b1, 1'b1, 8'h44, 1'b1);
    push(1'b0, 1'b1, 8'h55, 1'b0);
    check("t2_level_full", {29'd0, fifo_level}, 32'd4);
    check("t2_ready_full", {31'd0, cmd_ready}, 32'd0);
    pulse_done();
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      wait_start("t2_q");
      pulse_done();
      exp_cnt++;
    end
    wait_idle("t2");
    check("t2_level_empty", {29'd0, fifo_level}, 32'd0);
    check("t2_ready", {31'd0, cmd_ready}, 32'd1);
    check("t2_count", {24'd0, done_count}, exp_cnt);

    // 3: done held high across the next transaction is not a completion
    push(1'b1, 1'b0, 8'h6A, 1'b1);
    push(1'b0, 1'b1, 8'h96, 1'b1);
    wait_start("t3_a");
    @(posedge clk); #1 txn_done = 1'b1;
    exp_cnt++;
    wait_start("t3_b");
    check("t3_err_pre", {31'd0, err_timeout}, 32'd0);
`ifdef I2C_SEQ_RETRY_EN
    exp_q.push_back({1'b0, 1'b1, 8'h96});
    wait_start("t3_b_retry");
`endif
    wait_idle("t3");
    check("t3_err", {31'd0, err_timeout}, 32'd1);
    check("t3_count", {24'd0, done_count}, exp_cnt);
    txn_done = 1'b0;
    pulse_clr();
    check("t3_err_clr", {31'd0, err_timeout}, 32'd0);

    // 4: no completion at all; exact timeout position
    @(posedge clk); #1;
    s0 = start_cnt;
    push(1'b1, 1'b1, 8'hC3, 1'b1);
    exp_starts = 1;
`ifdef I2C_SEQ_RETRY_EN
    exp_q.push_back({1'b1, 1'b1, 8'hC3});
    exp_starts = 2;
`endif
    wait_start("t4_first");
`ifdef I2C_SEQ_RETRY_EN
    wait_start("t4_retry");
`endif
    repeat (TO) @(posedge clk);
    #1;
    check("t4_err_before", {31'd0, err_timeout}, 32'd0);
    @(posedge clk); #1;
    check("t4_err_at", {31'd0, err_timeout}, 32'd1);
    wait_idle("t4");
    check("t4_starts", start_cnt - s0, exp_starts);
    check("t4_count", {24'd0, done_count}, exp_cnt);

    // 5: reset while waiting with two commands queued
    push(1'b0, 1'b0, 8'h11, 1'b1);
    wait_start("t5_d");
    @(posedge clk); #1;
    push(1'b1, 1'b0, 8'h22, 1'b1);
    push(1'b0, 1'b1, 8'h33, 1'b1);
    check("t5_level_q", {29'd0, fifo_level}, 32'd2);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    check("t5_start", {31'd0, txn_start}, 32'd0);
    check("t5_fields", {22'd0, txn_rw, txn_slave_sel, txn_data}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_level", {29'd0, fifo_level}, 32'd0);
    check("t5_ready", {31'd0, cmd_ready}, 32'd1);
    check("t5_err", {31'd0, err_timeout}, 32'd0);
    check("t5_count", {24'd0, done_count}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    s0 = start_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_start", start_cnt - s0, 32'd0);
    check("t5_idle", {31'd0, busy}, 32'd0);
    push(1'b1, 1'b1, 8'h5A, 1'b1);
    wait_start("t5_new");
    pulse_done();
    exp_cnt++;
    wait_idle("t5");
    check("t5_count_new", {24'd0, done_count}, exp_cnt);

    // 6a: done edge lands on the last timeout cycle; completion wins
    push(1'b0, 1'b1, 8'hE7, 1'b1);
    wait_start("t6a");
    repeat (TO - 1) @(posedge clk);
    #1 txn_done = 1'b1;
    @(posedge clk); #1 txn_done = 1'b0;
    @(posedge clk); #1;
    exp_cnt++;
    check("t6a_count", {24'd0, done_count}, exp_cnt);
    check("t6a_err", {31'd0, err_timeout}, 32'd0);
    check("t6a_busy_gap", {31'd0, busy}, 32'd1);
    wait_idle("t6a");

    // 6b: err_clr coincident with a new timeout; set wins
    push(1'b1, 1'b0, 8'h7E, 1'b1);
`ifdef I2C_SEQ_RETRY_EN
    exp_q.push_back({1'b1, 1'b0, 8'h7E});
`endif
    wait_start("t6b");
`ifdef I2C_SEQ_RETRY_EN
    wait_start("t6b_retry");
`endif
    repeat (TO) @(posedge clk);
    #1;
    check("t6b_err_before", {31'd0, err_timeout}, 32'd0);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("t6b_set_wins", {31'd0, err_timeout}, 32'd1);
    wait_idle("t6b");
    pulse_clr();
    check("t6b_cleared", {31'd0, err_timeout}, 32'd0);
    check("t6b_count", {24'd0, done_count}, exp_cnt);
    check("end_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
